icache_fill_responder: RTL and testbench

- Memory-side end of the instruction-cache miss interface.
- Accepts line-fill requests (req_valid_miss / req_info_miss) from the fetch stage's instruction cache and queues them in order.
- Models main-memory latency with a down-counter, reads a backing line array, and returns one full cache line per request with the originating thread ID, or a bus error.
- Sits between fetch and the main-memory model in the core testbench/SoC top.

---
 rtl/icache_fill_responder_pkg.sv | 24 ++
 rtl/icache_fill_responder_fill_req_fifo.sv | 62 ++++++
 rtl/icache_fill_responder.sv | 131 +++++++++++++
 tb/tb_icache_fill_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_fill_responder_pkg.sv
// Shared types and defaults for the instruction-cache fill responder.
// Holds the miss-request bundle, the fill FSM states and the SoC-level sizes.
package icache_fill_responder_pkg;

    localparam int PHY_ADDR_W          = 32;
    localparam int THR_PER_CORE        = 4;
    localparam int THR_W               = 2;
    localparam int ICACHE_LINE_W       = 128;
    localparam int LINE_OFF_W          = $clog2(ICACHE_LINE_W / 8);
    localparam int MAIN_MEMORY_LATENCY = 10;
    localparam int MAIN_MEMORY_LINES   = 4096;

    typedef struct packed {
        logic [PHY_ADDR_W-1:0] addr;
        logic [THR_W-1:0]      thr_id;
    } memory_request_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } fill_state_t;

endpackage

// File: rtl/icache_fill_responder_fill_req_fifo.sv
// Generic synchronous fall-through FIFO: when empty, o_data shows i_data so
// a same-edge push+pop passes straight through without being stored.
// Ports: clock, reset (async, active-low), i_push/i_data, i_pop, o_data,
// o_full, o_empty (storage empty), o_count (stored entries).
module fill_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_data,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic          w_wr;
    logic          w_rd;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_count = r_cnt;
    assign o_data  = o_empty ? i_data : r_mem[r_rd];

    assign w_rd = i_pop && !o_empty;
    // A pop on an empty FIFO consumes the incoming word directly.
    assign w_wr = i_push && (!o_full || i_pop) && !(o_empty && i_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wr <= nxt(r_wr);
            if (w_rd) r_rd <= nxt(r_rd);
            if (w_wr && !w_rd)
                r_cnt <= r_cnt + 1'b1;
            else if (!w_wr && w_rd)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/icache_fill_responder.sv
// Memory side of the I-cache miss path: queues fill requests in order,
// waits MEM_LATENCY cycles each, returns a full line (or bus error).
// Ports: clock, reset (async, active-low); req_valid_miss/req_info_miss in;
// rsp_valid_miss/rsp_thread_id/rsp_data_miss/rsp_bus_error out;
// init_wr_en/init_wr_line/init_wr_data backdoor preload; ovf_error sticky.
module icache_fill_responder
    import icache_fill_responder_pkg::*;
#(
    parameter int                    MEM_LATENCY = MAIN_MEMORY_LATENCY,
    parameter int                    FIFO_DEPTH  = THR_PER_CORE,
    parameter int                    MEM_LINES   = MAIN_MEMORY_LINES,
    parameter logic [PHY_ADDR_W-1:0] MEM_BASE    = '0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid_miss,
    input  memory_request_t               req_info_miss,
    output logic                          rsp_valid_miss,
    output logic [THR_W-1:0]              rsp_thread_id,
    output logic [ICACHE_LINE_W-1:0]      rsp_data_miss,
    output logic                          rsp_bus_error,
    input  logic                          init_wr_en,
    input  logic [$clog2(MEM_LINES)-1:0]  init_wr_line,
    input  logic [ICACHE_LINE_W-1:0]      init_wr_data,
    output logic                          ovf_error
);

    localparam int LIW   = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(MEM_LATENCY);
    localparam int QW    = $bits(memory_request_t);

    fill_state_t             r_state;
    logic [CNT_W-1:0]        r_cnt;
    memory_request_t         r_req;
    logic                    r_rsp_valid;
    logic [THR_W-1:0]        r_thr;
    logic [ICACHE_LINE_W-1:0] r_data;
    logic                    r_bus_error;
    logic                    r_ovf;
    logic [ICACHE_LINE_W-1:0] r_mem [MEM_LINES];

    memory_request_t         w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_avail;
    logic                    w_pop;
    logic                    w_ovf;
    logic [$clog2(FIFO_DEPTH+1)-1:0] w_unused_cnt;
    logic                    w_borrow;
    logic [PHY_ADDR_W-1:0]   w_off;
    logic [PHY_ADDR_W-1:0]   w_line;
    logic                    w_berr;
    logic [LIW-1:0]          w_idx;

    fill_req_fifo #(
        .W     (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (req_valid_miss),
        .i_data  (req_info_miss),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_unused_cnt)
    );

    // Fall-through: a request arriving this edge counts as available.
    assign w_avail = req_valid_miss || !w_empty;
    assign w_pop   = w_avail && (r_state != WAIT);
    assign w_ovf   = req_valid_miss && w_full && !w_pop;

    // Borrow out of the base subtraction flags addr < MEM_BASE.
    assign {w_borrow, w_off} = {1'b0, r_req.addr} - {1'b0, MEM_BASE};
    assign w_line = w_off >> LINE_OFF_W;
    assign w_berr = w_borrow || (w_line >= PHY_ADDR_W'(MEM_LINES));
    assign w_idx  = w_line[LIW-1:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req       <= '0;
            r_rsp_valid <= 1'b0;
            r_thr       <= '0;
            r_data      <= '0;
            r_bus_error <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_ovf) r_ovf <= 1'b1;
            unique case (r_state)
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_valid <= 1'b1;
                        r_thr       <= r_req.thr_id;
                        r_bus_error <= w_berr;
                        r_data      <= w_berr ? '0 : r_mem[w_idx];
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_req   <= w_head;
                        r_cnt   <= CNT_W'(MEM_LATENCY - 2);
                        r_state <= WAIT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Backing store is never reset so a preloaded program survives reset.
    always_ff @(posedge clock) begin
        if (init_wr_en && (int'(init_wr_line) < MEM_LINES))
            r_mem[init_wr_line] <= init_wr_data;
    end

    assign rsp_valid_miss = r_rsp_valid;
    assign rsp_thread_id  = r_thr;
    assign rsp_data_miss  = r_data;
    assign rsp_bus_error  = r_bus_error;
    assign ovf_error      = r_ovf;

endmodule

// File: tb/tb_icache_fill_responder.sv
// Self-checking bench for icache_fill_responder: directed scenarios plus
// random traffic checked against a timing/queue reference model.
module tb_icache_fill_responder;
    import icache_fill_responder_pkg::*;

    localparam int LAT   = 10;
    localparam int DEPTH = 4;
    localparam int LINES = 4096;
    localparam logic [31:0]  BASE = 32'h0;
    localparam logic [127:0] PAT  = {16{8'hA5}};
    localparam logic [127:0] NEWD = {4{32'h1234_5678}};

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            req_valid_miss = 1'b0;
    memory_request_t req_info_miss = '0;
    logic            rsp_valid_miss;
    logic [1:0]      rsp_thread_id;
    logic [127:0]    rsp_data_miss;
    logic            rsp_bus_error;
    logic            init_wr_en = 1'b0;
    logic [11:0]     init_wr_line = '0;
    logic [127:0]    init_wr_data = '0;
    logic            ovf_error;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clock = ~clock;

    icache_fill_responder #(
        .MEM_LATENCY (LAT),
        .FIFO_DEPTH  (DEPTH),
        .MEM_LINES   (LINES),
        .MEM_BASE    (BASE)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid_miss (req_valid_miss),
        .req_info_miss  (req_info_miss),
        .rsp_valid_miss (rsp_valid_miss),
        .rsp_thread_id  (rsp_thread_id),
        .rsp_data_miss  (rsp_data_miss),
        .rsp_bus_error  (rsp_bus_error),
        .init_wr_en     (init_wr_en),
        .init_wr_line   (init_wr_line),
        .init_wr_data   (init_wr_data),
        .ovf_error      (ovf_error)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          t;
        logic [31:0] addr;
        logic [1:0]  thr;
    } pend_t;

    pend_t        q[$];
    logic [127:0] mmem [int];
    int           edge_n = 0;
    int           last_t = -1000;
    logic         m_ovf  = 1'b0;

    initial begin
        logic         s_rst, s_rv, s_we;
        logic [31:0]  s_a;
        logic [1:0]   s_th;
        logic [11:0]  s_wl;
        logic [127:0] s_wd;
        logic         e_v, e_be;
        logic [1:0]   e_th;
        logic [127:0] e_d;
        pend_t        p;
        int           line, busy, t;
        forever begin
            @(posedge clock);
            s_rst = reset;
            s_rv  = req_valid_miss;
            s_a   = req_info_miss.addr;
            s_th  = req_info_miss.thr_id;
            s_we  = init_wr_en;
            s_wl  = init_wr_line;
            s_wd  = init_wr_data;
            edge_n++;
            e_v = 1'b0; e_be = 1'b0; e_th = '0; e_d = '0;
            if (!s_rst) begin
                q.delete();
                last_t = -1000;
                m_ovf  = 1'b0;
            end else if (q.size() > 0 && q[0].t == edge_n) begin
                p    = q.pop_front();
                e_v  = 1'b1;
                e_th = p.thr;
                line = int'((p.addr - BASE) >> 4);
                if (p.addr < BASE || line >= LINES) e_be = 1'b1;
                else e_d = mmem[line];
            end
            // The write lands after any read captured on the same edge.
            if (s_we && int'(s_wl) < LINES) mmem[int'(s_wl)] = s_wd;
            if (s_rst && s_rv) begin
                busy = 0;
                foreach (q[i]) if (q[i].t - (LAT - 1) > edge_n) busy++;
                if (busy == DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    t = (edge_n + LAT - 1 > last_t + LAT) ?
                        edge_n + LAT - 1 : last_t + LAT;
                    q.push_back('{t, s_a, s_th});
                    last_t = t;
                end
            end
            #1;
            chk("valid", rsp_valid_miss, e_v);
            if (e_v) begin
                chk("thr", rsp_thread_id, e_th);
                chk("data", rsp_data_miss, e_d);
                chk("berr", rsp_bus_error, e_be);
            end
            chk("ovf", ovf_error, m_ovf);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        req_valid_miss = 1'b0;
        init_wr_en     = 1'b0;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [1:0] th);
        req_valid_miss       = 1'b1;
        req_info_miss.addr   = a;
        req_info_miss.thr_id = th;
        init_wr_en           = 1'b0;
    endtask

    task automatic send(input logic [31:0] a, input logic [1:0] th);
        @(negedge clock);
        set_req(a, th);
    endtask

    task automatic wr_line(input int ln, input logic [127:0] d);
        @(negedge clock);
        req_valid_miss = 1'b0;
        init_wr_en     = 1'b1;
        init_wr_line   = 12'(ln);
        init_wr_data   = d;
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge clock);
            set_idle();
        end
    endtask

    task automatic wait_rsp(output int k);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            set_idle();
            if (rsp_valid_miss) begin
                k = i;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int k;
        int r;
        repeat (3) @(negedge clock);
        chk("rst_valid", rsp_valid_miss, 1'b0);
        chk("rst_data", rsp_data_miss, '0);
        chk("rst_thr", rsp_thread_id, '0);
        chk("rst_berr", rsp_bus_error, 1'b0);
        chk("rst_ovf", ovf_error, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 64; i++)
            wr_line(i, (i == 3) ? PAT :
                    {$urandom, $urandom, $urandom, $urandom});
        quiet(2);

        // single request, latency and data
        send(32'h30, 2'd1);
        wait_rsp(k);
        chk("lat1", k, 10);
        chk("d1", rsp_data_miss, PAT);
        chk("th1", rsp_thread_id, 2'd1);
        chk("be1", rsp_bus_error, 1'b0);
        quiet(5);

        // first line past the array
        send(32'(LINES * 16), 2'd2);
        wait_rsp(k);
        chk("lat_be", k, 10);
        chk("be2", rsp_bus_error, 1'b1);
        chk("d2", rsp_data_miss, '0);
        quiet(5);

        // back to back, served in order
        send(32'h30, 2'd0);
        send(32'h44, 2'd1);
        wait_rsp(k);
        chk("b2b_lat0", k, 9);
        chk("b2b_th0", rsp_thread_id, 2'd0);
        wait_rsp(k);
        chk("b2b_lat1", k, 10);
        chk("b2b_th1", rsp_thread_id, 2'd1);
        quiet(5);

        // one in flight, then five in a row: the fifth is dropped
        send(32'h10, 2'd0);
        for (int i = 0; i < 5; i++) send(32'(16 * (i + 4)), 2'(i));
        quiet(1);
        chk("ovf_set", ovf_error, 1'b1);
        quiet(60);
        chk("ovf_sticky", ovf_error, 1'b1);

        // reset mid-WAIT with two queued
        send(32'h30, 2'd0);
        send(32'h40, 2'd1);
        send(32'h50, 2'd2);
        quiet(3);
        @(negedge clock);
        reset = 1'b0;
        set_idle();
        #1;
        chk("mrst_valid", rsp_valid_miss, 1'b0);
        chk("mrst_data", rsp_data_miss, '0);
        chk("mrst_thr", rsp_thread_id, '0);
        chk("mrst_ovf", ovf_error, 1'b0);
        quiet(2);
        @(negedge clock);
        reset = 1'b1;
        quiet(30);
        send(32'h30, 2'd2);
        wait_rsp(k);
        chk("post_lat", k, 10);
        chk("post_d", rsp_data_miss, PAT);
        chk("post_th", rsp_thread_id, 2'd2);
        quiet(5);

        // write on the capture edge: old data, then new data
        send(32'h30, 2'd3);
        quiet(8);
        wr_line(3, NEWD);
        @(negedge clock);
        chk("col_v", rsp_valid_miss, 1'b1);
        chk("col_old", rsp_data_miss, PAT);
        set_req(32'h30, 2'd3);
        wait_rsp(k);
        chk("col_lat", k, 10);
        chk("col_new", rsp_data_miss, NEWD);
        quiet(5);

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 99);
            if (r < 15)
                send(32'($urandom_range(0, 63) * 16 + $urandom_range(0, 15)),
                     2'($urandom_range(0, 3)));
            else if (r < 18)
                send(32'h0001_0000 + ($urandom & 32'h0FFF_FFFF),
                     2'($urandom_range(0, 3)));
            else if (r < 25)
                wr_line($urandom_range(0, 63),
                        {$urandom, $urandom, $urandom, $urandom});
            else if (r < 27)
                for (int b = 0; b < 6; b++)
                    send(32'($urandom_range(0, 63) * 16),
                         2'($urandom_range(0, 3)));
            else
                quiet(1);
        end
        quiet(DEPTH * LAT + 2 * LAT);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
